// File: rtl/add_stream_pkg.sv
// -----------------------------------------------------------------------------
// add_stream_pkg
// Shared definitions for the add_stream_ctrl streaming adder wrapper.
//   N_DEF / DEPTH_DEF : default operand width and operand FIFO depth
//   PTR_W             : FIFO pointer width for the default depth
//   MAX_POS / MAX_NEG : saturation limits at the default width
//   res_t             : registered result record {sum, cout, ovf}
//   OVF_CNT_W         : width of the overflow event counter
//   sat_inc_cnt()     : saturating +1 for the overflow event counter
// -----------------------------------------------------------------------------
package add_stream_pkg;

    localparam int N_DEF     = 32;
    localparam int DEPTH_DEF = 4;
    localparam int PTR_W     = $clog2(DEPTH_DEF);

    localparam logic [N_DEF-1:0] MAX_POS = {1'b0, {(N_DEF-1){1'b1}}};
    localparam logic [N_DEF-1:0] MAX_NEG = {1'b1, {(N_DEF-1){1'b0}}};

    localparam int                 OVF_CNT_W   = 16;
    localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = {OVF_CNT_W{1'b1}};

    typedef struct packed {
        logic [N_DEF-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [OVF_CNT_W-1:0] sat_inc_cnt(input logic [OVF_CNT_W-1:0] cnt);
        if (cnt == OVF_CNT_MAX) begin
            return cnt;
        end
        return cnt + OVF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/op_fifo.sv
// -----------------------------------------------------------------------------
// op_fifo
// DEPTH-entry operand FIFO with an occupancy counter and a combinational
// read of the head entry (the head feeds the external adder directly).
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-high (empties the FIFO)
//   flush_i    : synchronous clear; wins over push/pop in the same cycle
//   push_i     : write wr_data_i at the tail (caller guarantees !full_o)
//   pop_i      : retire the head entry (caller guarantees !empty_o)
//   wr_data_i  : W-bit entry to store
//   rd_data_o  : W-bit head entry (stale storage when empty; caller masks)
//   full_o     : count == DEPTH
//   empty_o    : count == 0
// -----------------------------------------------------------------------------
module op_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wr_data_i,
    output logic [W-1:0] rd_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] wr_en;

    logic do_push;
    logic do_pop;

    // Flush dominates: a push or pop in the flush cycle is dropped.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i  && !flush_i;

    // One-hot write enable per storage entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = do_push && (wr_ptr_q == PTR_W'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_q[i] <= wr_data_i;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/add_stream_ctrl.sv
// -----------------------------------------------------------------------------
// add_stream_ctrl
// Streaming front/back end for an external combinational N-bit adder.
// Operand pairs are buffered in op_fifo; the FIFO head drives the adder, and
// the adder's sum/carry/overflow are captured into a valid/ready result stage.
// A saturating 16-bit counter records how many loaded results overflowed.
//
// Build option: define SATURATE_EN to clamp the registered sum on signed
// overflow (MAX_POS when the head A is non-negative, MAX_NEG otherwise).
// Without it the wrapped two's-complement sum is passed through.
//
// Ports:
//   clk, rst       : clock / synchronous active-high reset
//   flush          : clears FIFO and result stage, keeps ovf_count
//   in_valid/ready : operand handshake, in_a / in_b signed operands
//   adder_a/b      : FIFO head to adder (0 when FIFO empty)
//   adder_sum/cout/ovf : combinational adder return
//   out_valid/ready: result handshake, out_sum / out_cout / out_ovf
//   ovf_count      : overflow results loaded, saturates at 16'hFFFF
//   busy           : FIFO non-empty or a result is held
// -----------------------------------------------------------------------------
module add_stream_ctrl
    import add_stream_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_a,
    input  logic [N-1:0]         in_b,
    output logic [N-1:0]         adder_a,
    output logic [N-1:0]         adder_b,
    input  logic [N-1:0]         adder_sum,
    input  logic                 adder_cout,
    input  logic                 adder_ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_sum,
    output logic                 out_cout,
    output logic                 out_ovf,
    output logic [OVF_CNT_W-1:0] ovf_count,
    output logic                 busy
);

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } result_t;

`ifdef SATURATE_EN
    localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};
`endif

    logic [2*N-1:0] fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;

    result_t                result_q,    result_d;
    logic                   out_valid_q, out_valid_d;
    logic [OVF_CNT_W-1:0]   ovf_count_q, ovf_count_d;

    // in_ready deliberately ignores a same-cycle pop: no full-FIFO bypass.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = !fifo_empty && (!out_valid_q || out_ready);

    op_fifo #(
        .W     (2 * N),
        .DEPTH (DEPTH)
    ) u_op_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i ({in_a, in_b}),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Mask the head so the adder sees zeros rather than stale storage.
    assign adder_a = fifo_empty ? '0 : fifo_head[2*N-1:N];
    assign adder_b = fifo_empty ? '0 : fifo_head[N-1:0];

    always_comb begin
        result_d    = result_q;
        out_valid_d = out_valid_q;
        ovf_count_d = ovf_count_q;
        if (pop) begin
            result_d.sum  = adder_sum;
`ifdef SATURATE_EN
            // Overflow direction follows the sign of the operands, which
            // match whenever signed overflow occurs; A's MSB decides.
            if (adder_ovf) begin
                result_d.sum = adder_a[N-1] ? SAT_NEG : SAT_POS;
            end
`endif
            result_d.cout = adder_cout;
            result_d.ovf  = adder_ovf;
            out_valid_d   = 1'b1;
            if (adder_ovf) begin
                ovf_count_d = sat_inc_cnt(ovf_count_q);
            end
        end else if (out_valid_q && out_ready) begin
            // Drained with nothing behind it; data regs keep last value.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
            ovf_count_q <= '0;
        end else if (flush) begin
            // Held result is discarded; the event counter survives.
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = result_q.sum;
    assign out_cout  = result_q.cout;
    assign out_ovf   = result_q.ovf;
    assign ovf_count = ovf_count_q;
    assign busy      = !fifo_empty || out_valid_q;

endmodule

// File: tb/tb_add_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_add_stream_ctrl
// Directed bench for add_stream_ctrl (N=32, DEPTH=4) with a behavioural
// carry/overflow adder closing the loop on adder_a/adder_b.
// -----------------------------------------------------------------------------
module tb_add_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] adder_a;
    logic [31:0] adder_b;
    logic [31:0] adder_sum;
    logic        adder_cout;
    logic        adder_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic [15:0] ovf_count;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    add_stream_ctrl #(.N(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .adder_ovf  (adder_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .ovf_count  (ovf_count),
        .busy       (busy)
    );

    // Behavioural stand-in for the external carry-skip adder.
    always_comb begin
        {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b};
        adder_ovf = (adder_a[31] == adder_b[31]) && (adder_sum[31] != adder_a[31]);
    end

    // Expected registered result {cout, ovf, sum} for one operand pair.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        logic        c;
        logic        o;
        {c, s} = {1'b0, a} + {1'b0, b};
        o = (a[31] == b[31]) && (s[31] != a[31]);
`ifdef SATURATE_EN
        if (o) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {c, o, s};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    int          idx;
    int          sent;
    int          recv;
    int          cyc;
    int          ovf_model;
    logic        acc;
    logic [33:0] e;
    logic [33:0] sb_q[$];
    logic [31:0] bp_a   [6] = '{32'd3, 32'd103, 32'd203, 32'd303, 32'd403, 32'd503};
    logic [31:0] bp_b   [6] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    logic [31:0] bp_sum [5] = '{32'd4, 32'd105, 32'd206, 32'd307, 32'd408};
    logic [31:0] sa     [100];
    logic [31:0] sbv    [100];

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // ---- 1: reset ----
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_ovf_count", ovf_count, 0);
        check("rst_adder_a",   adder_a,   0);
        check("rst_out_sum",   out_sum,   0);
        check("rst_busy",      busy,      0);
        rst = 1'b0;

        // ---- 2: single op 5 + 7 ----
        out_ready = 1'b1;
        push_pair(32'd5, 32'd7);
        check("single_not_yet", out_valid, 0);
        check("single_head_a",  adder_a,   5);
        tick();
        check("single_valid", out_valid, 1);
        check("single_sum",   out_sum,   12);
        check("single_cout",  out_cout,  0);
        check("single_ovf",   out_ovf,   0);
        $display("txn single: a=5 b=7 sum=%0d", out_sum);
        tick();
        check("single_drain", out_valid, 0);

        // ---- 3: backpressure ----
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1;
            in_a     = bp_a[idx];
            in_b     = bp_b[idx];
            acc      = in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("bp_accepted",  idx,      5);
        check("bp_in_ready",  in_ready, 0);
        check("bp_hold_sum",  out_sum,  4);
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            check("bp_res_valid", out_valid, 1);
            check("bp_res_sum",   out_sum,   bp_sum[j]);
            $display("txn bp %0d: sum=%0d", j, out_sum);
            tick();
        end
        check("bp_empty", out_valid, 0);
        check("bp_idle",  busy,      0);

        // ---- 4: overflow ----
        push_pair(32'h7FFF_FFFF, 32'd1);
        tick();
        check("ovf1_ovf",   out_ovf,   1);
        check("ovf1_cout",  out_cout,  0);
        check("ovf1_count", ovf_count, 1);
`ifdef SATURATE_EN
        check("ovf1_sum", out_sum, 32'h7FFF_FFFF);
`else
        check("ovf1_sum", out_sum, 32'h8000_0000);
`endif
        $display("txn ovf1: sum=%h ovf=%0d", out_sum, out_ovf);
        push_pair(32'h8000_0000, 32'h8000_0000);
        tick();
        check("ovf2_ovf",   out_ovf,   1);
        check("ovf2_cout",  out_cout,  1);
        check("ovf2_count", ovf_count, 2);
`ifdef SATURATE_EN
        check("ovf2_sum", out_sum, 32'h8000_0000);
`else
        check("ovf2_sum", out_sum, 32'h0000_0000);
`endif
        $display("txn ovf2: sum=%h cout=%0d ovf=%0d", out_sum, out_cout, out_ovf);
        tick();

        // ---- 5: flush then reset mid-stream ----
        out_ready = 1'b0;
        push_pair(32'h7FFF_FFFF, 32'd1);
        push_pair(32'd1, 32'd1);
        push_pair(32'd2, 32'd2);
        push_pair(32'd3, 32'd3);
        check("fl_pre_valid", out_valid, 1);
        check("fl_pre_count", ovf_count, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid",    out_valid, 0);
        check("fl_busy",     busy,      0);
        check("fl_count",    ovf_count, 3);
        check("fl_in_ready", in_ready,  1);
        check("fl_adder_a",  adder_a,   0);
        out_ready = 1'b1;
        tick();
        tick();
        check("fl_no_emit", out_valid, 0);
        out_ready = 1'b0;
        push_pair(32'h7FFF_FFFF, 32'd1);
        push_pair(32'd1, 32'd1);
        push_pair(32'd2, 32'd2);
        push_pair(32'd3, 32'd3);
        check("rs_pre_count", ovf_count, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_valid", out_valid, 0);
        check("rs_busy",  busy,      0);
        check("rs_count", ovf_count, 0);
        check("rs_sum",   out_sum,   0);

        // ---- 6: streaming ----
        for (int i = 0; i < 100; i++) begin
            sa[i]  = $urandom;
            sbv[i] = $urandom;
            if (i % 10 == 0) begin
                sa[i]  = 32'h7FFF_FF00;
                sbv[i] = 32'h0000_0100 + 32'(i);
            end
        end
        out_ready = 1'b1;
        sent = 0;
        recv = 0;
        cyc  = 0;
        ovf_model = 0;
        while (recv < 100 && cyc < 400) begin
            if (sent < 100) begin
                in_valid = 1'b1;
                in_a     = sa[sent];
                in_b     = sbv[sent];
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                e = model(sa[sent], sbv[sent]);
                sb_q.push_back(e);
                if (e[32]) ovf_model++;
                sent++;
            end
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("stream_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("stream_sum",  out_sum,  e[31:0]);
                    check("stream_cout", out_cout, e[33]);
                    check("stream_ovf",  out_ovf,  e[32]);
                end
                $display("txn stream %0d: sum=%h cout=%0d ovf=%0d", recv, out_sum, out_cout, out_ovf);
                recv++;
            end
        end
        in_valid = 1'b0;
        check("stream_recv",   recv,      100);
        check("stream_cycles", cyc,       101);
        check("stream_ovfcnt", ovf_count, ovf_model);
        tick();
        check("stream_idle",   busy,      0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
